alu_logic_result_stage: RTL and testbench

//  Registered output stage for the ALU logic unit. Accepts operand pairs A/B and an
//  op select, and computes AND/OR/XOR/NOR over N bits. Captures the result with

---
 rtl/alu_logic_result_stage.sv | 112 +++++++++++
 tb/tb_alu_logic_result_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/alu_logic_result_stage.sv
// ALU logic unit (AND/OR/XOR/NOR) with registered result/flags held in a 2-entry skid buffer.
// One cycle from accept to out_valid; in_ready depends only on buffer occupancy, never on out_ready.
module alu_logic_result_stage #(
   parameter int N  = 32,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  A,
   input  logic [N-1:0]  B,
   input  logic [1:0]    OP,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  F,
   output logic          Z,
   output logic          NF,
   output logic [CW-1:0] CNT
);

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

   state_t         state;
   state_t         state_nxt;
   logic [N-1:0]   res;
   logic           res_z;
   logic           res_nf;
   logic [N-1:0]   skid_f;
   logic           skid_z;
   logic           skid_nf;
   logic           push;
   logic           pop;

   always_comb begin
      res = '0;
      case (OP)
         2'b00:   res = A & B;
         2'b01:   res = A | B;
         2'b10:   res = A ^ B;
         default: res = ~(A | B);
      endcase
   end

   assign res_z  = (res == '0);
   assign res_nf = res[N-1];
   assign push   = in_valid & in_ready;
   assign pop    = out_valid & out_ready;

   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY: if (push) state_nxt = ONE;
         ONE: begin
            if (push && !pop)      state_nxt = FULL;
            else if (!push && pop) state_nxt = EMPTY;
         end
         FULL:  if (pop) state_nxt = ONE;
         default: state_nxt = EMPTY;
      endcase
   end

   // Handshake flags are registered off the next state so they match the buffer occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= EMPTY;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         F         <= '0;
         Z         <= 1'b0;
         NF        <= 1'b0;
         skid_f    <= '0;
         skid_z    <= 1'b0;
         skid_nf   <= 1'b0;
         CNT       <= '0;
      end else begin
         state     <= state_nxt;
         in_ready  <= (state_nxt != FULL);
         out_valid <= (state_nxt != EMPTY);
         case (state)
            EMPTY: begin
               if (push) begin
                  F  <= res;
                  Z  <= res_z;
                  NF <= res_nf;
               end
            end
            ONE: begin
               if (push && pop) begin
                  F  <= res;
                  Z  <= res_z;
                  NF <= res_nf;
               end else if (push) begin
                  skid_f  <= res;
                  skid_z  <= res_z;
                  skid_nf <= res_nf;
               end
            end
            FULL: begin
               if (pop) begin
                  F  <= skid_f;
                  Z  <= skid_z;
                  NF <= skid_nf;
               end
            end
            default: ;
         endcase
         if (pop) CNT <= CNT + CW'(1);
      end
   end

endmodule

// File: tb/tb_alu_logic_result_stage.sv
// Directed bench for alu_logic_result_stage: driver queues expected results, a monitor checks pops.
module tb_alu_logic_result_stage;

   localparam int N  = 32;
   localparam int CW = 8;

   typedef struct packed {
      logic [N-1:0] f;
      logic         z;
      logic         nf;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [N-1:0]  A = '0;
   logic [N-1:0]  B = '0;
   logic [1:0]    OP = 2'b00;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [N-1:0]  F;
   logic          Z;
   logic          NF;
   logic [CW-1:0] CNT;

   exp_t          sb[$];
   logic [CW-1:0] exp_cnt = '0;
   int            n_vec = 0;
   int            n_bad = 0;

   alu_logic_result_stage #(.N(N), .CW(CW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .OP(OP), .out_valid(out_valid), .out_ready(out_ready),
      .F(F), .Z(Z), .NF(NF), .CNT(CNT)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic [1:0] op);
      exp_t e;
      case (op)
         2'b00:   e.f = a & b;
         2'b01:   e.f = a | b;
         2'b10:   e.f = a ^ b;
         default: e.f = ~(a | b);
      endcase
      e.z  = (e.f == '0);
      e.nf = e.f[N-1];
      return e;
   endfunction

   // Drives one transfer; the expectation is queued only when the push is certain to happen.
   task automatic push(input logic [N-1:0] a, input logic [N-1:0] b, input logic [1:0] op,
                       input logic [N-1:0] ef, input logic ez, input logic en);
      bit ok;
      exp_t e;
      ok = 0;
      A = a; B = b; OP = op; in_valid = 1'b1;
      e.f = ef; e.z = ez; e.nf = en;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back(e);
            ok = 1;
         end
         @(posedge clk);
         #1;
      end
      if (!ok) check("push_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         exp_cnt = '0;
      end else if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_out", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("F", 64'(F), 64'(e.f));
            check("Z", 64'(Z), 64'(e.z));
            check("NF", 64'(NF), 64'(e.nf));
         end
         check("CNT", 64'(CNT), 64'(exp_cnt));
         exp_cnt = exp_cnt + 1'b1;
      end
   end

   initial begin
      exp_t m;
      #15;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_F", 64'(F), 64'd0);
      check("rst_Z", 64'(Z), 64'd0);
      check("rst_NF", 64'(NF), 64'd0);
      check("rst_CNT", 64'(CNT), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #3;
      rst = 1'b0;
      cycles(1);
      check("in_ready_after_rst", 64'(in_ready), 64'd1);

      // Basic OR with zero result, then counter advance on the pop.
      out_ready = 1'b1;
      push(32'd0, 32'd0, 2'b01, 32'd0, 1'b1, 1'b0);
      check("lat_out_valid", 64'(out_valid), 64'd1);
      cycles(1);
      check("cnt_after_first", 64'(CNT), 64'd1);

      push(32'd14, 32'd2, 2'b01, 32'd14, 1'b0, 1'b0);
      push(32'd180, 32'd267, 2'b01, 32'd447, 1'b0, 1'b0);
      push(32'd1543, 32'd23, 2'b00, 32'd7, 1'b0, 1'b0);
      push(32'd1543, 32'd23, 2'b10, 32'd1552, 1'b0, 1'b0);
      push(32'd1543, 32'd23, 2'b11, 32'hFFFF_F9E8, 1'b0, 1'b1);
      cycles(2);

      // Stall downstream to fill both entries.
      out_ready = 1'b0;
      push(32'd1, 32'd2, 2'b01, 32'd3, 1'b0, 1'b0);
      push(32'd4, 32'd8, 2'b01, 32'd12, 1'b0, 1'b0);
      check("full_in_ready", 64'(in_ready), 64'd0);
      check("full_out_valid", 64'(out_valid), 64'd1);
      cycles(3);
      check("held_F", 64'(F), 64'd3);
      check("held_in_ready", 64'(in_ready), 64'd0);
      out_ready = 1'b1;
      cycles(3);
      check("drained_out_valid", 64'(out_valid), 64'd0);
      check("cnt_before_stream", 64'(CNT), 64'd8);

      // Ten back-to-back transfers with simultaneous push and pop.
      for (int i = 0; i < 10; i++) begin
         m = model(32'(i * 37 + 5), 32'(32'hA5A5_0000 >> i), 2'(i));
         push(32'(i * 37 + 5), 32'(32'hA5A5_0000 >> i), 2'(i), m.f, m.z, m.nf);
      end
      check("stream_cnt", 64'(CNT), 64'd17);
      check("stream_in_ready", 64'(in_ready), 64'd1);
      check("stream_out_valid", 64'(out_valid), 64'd1);
      cycles(1);
      check("stream_cnt_final", 64'(CNT), 64'd18);

      // Asynchronous reset while full.
      out_ready = 1'b0;
      push(32'hF0, 32'h0F, 2'b10, 32'hFF, 1'b0, 1'b0);
      push(32'h80000000, 32'h0, 2'b01, 32'h80000000, 1'b0, 1'b1);
      check("pre_rst_in_ready", 64'(in_ready), 64'd0);
      #2;
      rst = 1'b1;
      #1;
      check("arst_out_valid", 64'(out_valid), 64'd0);
      check("arst_F", 64'(F), 64'd0);
      check("arst_CNT", 64'(CNT), 64'd0);
      check("arst_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #3;
      rst = 1'b0;
      cycles(1);
      check("post_rst_in_ready", 64'(in_ready), 64'd1);
      check("post_rst_out_valid", 64'(out_valid), 64'd0);

      // 256 pops so CNT passes 255 and wraps to 0.
      out_ready = 1'b1;
      for (int i = 0; i < 256; i++) begin
         m = model(32'(i), 32'(~i), 2'(i >> 2));
         push(32'(i), 32'(~i), 2'(i >> 2), m.f, m.z, m.nf);
      end
      check("pre_wrap_cnt", 64'(CNT), 64'd255);
      cycles(1);
      check("wrap_cnt", 64'(CNT), 64'd0);
      check("sb_empty", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
